// File: rtl/fb_pkg.sv
// fb_pkg: shared types and helpers for the frame buffer ring.
// Bank lifecycle enum, ring increment and default frame geometry.
package fb_pkg;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        FULL,
        DISPLAY
    } bank_state_e;

    localparam int FRAME_W_DEF  = 200;
    localparam int FRAME_H_DEF  = 150;
    localparam int FRAME_PIXELS = FRAME_W_DEF * FRAME_H_DEF;

    function automatic int unsigned next_bank(
        input int unsigned idx,
        input int unsigned num_banks
    );
        return (idx + 1 >= num_banks) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fb_bank_mem.sv
// fb_bank_mem: one frame store, single write port and single read port.
// Read data is registered (1-cycle latency).
module fb_bank_mem
    import fb_pkg::*;
#(
    parameter int DEPTH = FRAME_PIXELS,
    parameter int BPP   = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [BPP-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [BPP-1:0] rdata
);

    logic [BPP-1:0] mem [DEPTH];

    // Write the accepted pixel and register the read word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_buffer_ring.sv
// frame_buffer_ring: N-bank ring of scaled frame stores, swapped at frame start.
// Optional: define FB_UNDERRUN_CNT_EN to implement underrun_cnt (else tied 0).
module frame_buffer_ring
    import fb_pkg::*;
#(
    parameter int FRAME_W     = 200,
    parameter int FRAME_H     = 150,
    parameter int SCALE_SHIFT = 2,
    parameter int BPP         = 1,
    parameter int NUM_BANKS   = 2,
    localparam int XW = $clog2(FRAME_W << SCALE_SHIFT),
    localparam int YW = $clog2(FRAME_H << SCALE_SHIFT),
    localparam int CW = $clog2(NUM_BANKS + 1)
) (
    input  logic           CLK_40,
    input  logic           reset_n,
    input  logic           wr_en,
    input  logic [BPP-1:0] wr_data,
    output logic           wr_ready,
    input  logic           frame_start,
    input  logic [XW-1:0]  rd_x,
    input  logic [YW-1:0]  rd_y,
    input  logic           rd_active,
    output logic [BPP-1:0] pix_out,
    output logic           pix_valid,
    output logic [CW-1:0]  full_banks,
    output logic           bank_full,
    output logic [15:0]    underrun_cnt
);

    localparam int NPIX = FRAME_W * FRAME_H;
    localparam int AW   = $clog2(NPIX);
    localparam int BW   = $clog2(NUM_BANKS);
    localparam int COLW = $clog2(FRAME_W + 1);
    localparam int ROWW = $clog2(FRAME_H + 1);

    bank_state_e st   [NUM_BANKS];
    bank_state_e st_n [NUM_BANKS];

    logic [BW-1:0]   wr_bank, wr_bank_n;
    logic [BW-1:0]   disp_idx, disp_idx_n;
    logic [BW-1:0]   disp_next, disp_next_n;
    logic [BW-1:0]   sel_q;
    logic            filling, filling_n;
    logic            disp_valid, disp_valid_n;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic            accept, last, swap;
    logic [AW-1:0]   waddr, raddr;
    logic [XW-1:0]   sx;
    logic [YW-1:0]   sy;
    logic            in_range;
    logic [CW-1:0]   nfull, full_q;
    logic            pv_q, po_q;
    logic [BPP-1:0]  rdata [NUM_BANKS];

    assign accept = wr_en && filling;
    assign last   = accept
                 && (col == COLW'(FRAME_W - 1))
                 && (row == ROWW'(FRAME_H - 1));
    assign waddr  = AW'(int'(row) * FRAME_W + int'(col));

    assign sx       = rd_x >> SCALE_SHIFT;
    assign sy       = rd_y >> SCALE_SHIFT;
    assign in_range = (int'(sx) < FRAME_W) && (int'(sy) < FRAME_H);
    assign raddr    = in_range
                    ? AW'(int'(sy) * FRAME_W + int'(sx))
                    : '0;

    // Next bank states: swap on registered state, then fill completion, then claim.
    always_comb begin
        st_n         = st;
        wr_bank_n    = wr_bank;
        filling_n    = filling;
        disp_idx_n   = disp_idx;
        disp_next_n  = disp_next;
        disp_valid_n = disp_valid;
        swap         = frame_start && (st[disp_next] == FULL);
        if (swap) begin
            if (disp_valid) begin
                st_n[disp_idx] = FREE;
            end
            st_n[disp_next] = DISPLAY;
            disp_idx_n      = disp_next;
            disp_valid_n    = 1'b1;
            disp_next_n     = BW'(next_bank(32'(disp_next), NUM_BANKS));
        end
        if (last) begin
            st_n[wr_bank] = FULL;
            wr_bank_n     = BW'(next_bank(32'(wr_bank), NUM_BANKS));
            filling_n     = 1'b0;
        end
        if (!filling_n && (st_n[wr_bank_n] == FREE)) begin
            st_n[wr_bank_n] = FILLING;
            filling_n       = 1'b1;
        end
        nfull = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (st_n[i] == FULL) begin
                nfull = nfull + CW'(1);
            end
        end
    end

    // Bank ownership and ring pointers.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st[i] <= (i == 0) ? FILLING : FREE;
            end
            wr_bank    <= '0;
            filling    <= 1'b1;
            disp_idx   <= '0;
            disp_next  <= '0;
            disp_valid <= 1'b0;
            full_q     <= '0;
        end else begin
            st         <= st_n;
            wr_bank    <= wr_bank_n;
            filling    <= filling_n;
            disp_idx   <= disp_idx_n;
            disp_next  <= disp_next_n;
            disp_valid <= disp_valid_n;
            full_q     <= nfull;
        end
    end

    // Write position within the filling frame.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COLW'(FRAME_W - 1)) begin
                col <= '0;
                row <= (row == ROWW'(FRAME_H - 1)) ? '0 : row + ROWW'(1);
            end else begin
                col <= col + COLW'(1);
            end
        end
    end

    // Read pipeline: qualify and remember which bank the read targeted.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            pv_q  <= 1'b0;
            po_q  <= 1'b0;
            sel_q <= '0;
        end else begin
            pv_q  <= rd_active && disp_valid;
            po_q  <= rd_active && disp_valid && in_range;
            sel_q <= disp_idx;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        fb_bank_mem #(
            .DEPTH (NPIX),
            .BPP   (BPP),
            .AW    (AW)
        ) u_mem (
            .clk   (CLK_40),
            .we    (accept && (wr_bank == BW'(b))),
            .waddr (waddr),
            .wdata (wr_data),
            .raddr (raddr),
            .rdata (rdata[b])
        );
    end

    assign pix_out    = po_q ? rdata[sel_q] : '0;
    assign pix_valid  = pv_q;
    assign wr_ready   = filling;
    assign bank_full  = ~filling;
    assign full_banks = full_q;

`ifdef FB_UNDERRUN_CNT_EN
    logic [15:0] under_q;

    // Count repeated frames once a frame has been shown; saturates.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            under_q <= '0;
        end else if (frame_start && !swap && disp_valid
                     && (under_q != 16'hFFFF)) begin
            under_q <= under_q + 16'd1;
        end
    end

    assign underrun_cnt = under_q;
`else
    assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_frame_buffer_ring.sv
// tb_frame_buffer_ring: directed bench for a 4x2, x2 scale, 3-bank ring.
// A queue-based frame model is compared against the DUT every cycle.
module tb_frame_buffer_ring;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int S   = 1;
    localparam int NB  = 3;
`ifdef FB_UNDERRUN_CNT_EN
    localparam int UEN = 1;
`else
    localparam int UEN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [0:0]  wr_data = 1'b0;
    logic        wr_ready;
    logic        frame_start = 1'b0;
    logic [2:0]  rd_x = '0;
    logic [1:0]  rd_y = '0;
    logic        rd_active = 1'b0;
    logic [0:0]  pix_out;
    logic        pix_valid;
    logic [1:0]  full_banks;
    logic        bank_full;
    logic [15:0] underrun_cnt;

    int total = 0;
    int bad   = 0;

    frame_buffer_ring #(
        .FRAME_W     (W),
        .FRAME_H     (H),
        .SCALE_SHIFT (S),
        .BPP         (1),
        .NUM_BANKS   (NB)
    ) dut (
        .CLK_40       (clk),
        .reset_n      (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .frame_start  (frame_start),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_active    (rd_active),
        .pix_out      (pix_out),
        .pix_valid    (pix_valid),
        .full_banks   (full_banks),
        .bank_full    (bank_full),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // Model: completed frames queue up; display pops the oldest.
    logic [7:0] m_ready [$];
    logic [7:0] m_disp  = '0;
    logic [7:0] m_buf   = '0;
    bit         m_dv    = 1'b0;
    bit         m_fill  = 1'b1;
    int         m_wc    = 0;
    int         m_under = 0;
    bit         e_pv    = 1'b0;
    bit         e_po    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready.delete();
            m_disp  = '0;
            m_buf   = '0;
            m_dv    = 1'b0;
            m_fill  = 1'b1;
            m_wc    = 0;
            m_under = 0;
            e_pv    = 1'b0;
            e_po    = 1'b0;
        end else begin
            int sxm, sym;
            sxm  = int'(rd_x) >> S;
            sym  = int'(rd_y) >> S;
            e_pv = rd_active && m_dv;
            e_po = e_pv && sxm < W && sym < H
                 && m_disp[sym * W + sxm];
            if (frame_start) begin
                if (m_ready.size() > 0) begin
                    m_disp = m_ready.pop_front();
                    m_dv   = 1'b1;
                end else if (m_dv && m_under < 65535) begin
                    m_under++;
                end
            end
            if (wr_en && m_fill) begin
                m_buf[m_wc] = wr_data[0];
                m_wc++;
                if (m_wc == W * H) begin
                    m_ready.push_back(m_buf);
                    m_wc   = 0;
                    m_fill = 1'b0;
                end
            end
            if (!m_fill && (m_ready.size() + (m_dv ? 1 : 0)) < NB) begin
                m_fill = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [21:0] exp_v, act_v;
            exp_v = {e_pv, e_po, m_fill, !m_fill,
                     2'(m_ready.size()), 16'(m_under * UEN)};
            act_v = {pix_valid, pix_out, wr_ready, bank_full,
                     full_banks, underrun_cnt};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL model t=%0t got=%h expected=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_beats(input logic [7:0] img, input int n);
        for (int k = 0; k < n; k++) begin
            wr_en   = 1'b1;
            wr_data = img[k];
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic scan(input bit act, input logic [7:0] img, input bit shown);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                rd_x      = 3'(x);
                rd_y      = 2'(y);
                rd_active = act;
                step();
                chk("scan_vld", int'(pix_valid), int'(act && shown));
                chk("scan_pix", int'(pix_out),
                    int'(act && shown && img[(y >> 1) * W + (x >> 1)]));
            end
        end
        rd_active = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] fa  = 8'b10100101;
    logic [7:0] fb  = 8'b10010110;
    logic [7:0] f1  = 8'b00001111;
    logic [7:0] f2  = 8'b10011001;
    logic [7:0] f3  = 8'b01011010;
    logic [7:0] f4  = 8'b11000011;
    logic [7:0] r01 = 8'b00110011;
    logic [7:0] r23 = 8'b11001100;

    initial begin
        #1;
        step();
        step();
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_out", int'(pix_out), 0);
        chk("rst_full_banks", int'(full_banks), 0);
        chk("rst_bank_full", int'(bank_full), 0);
        chk("rst_underrun", int'(underrun_cnt), 0);
        rst_n = 1'b1;

        scan(1'b1, fa, 1'b0);

        write_beats(fa, 8);
        chk("a_full_banks", int'(full_banks), 1);
        pulse_fs();
        chk("a_full_after_swap", int'(full_banks), 0);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                logic [7:0] row_v;
                rd_x      = 3'(x);
                rd_y      = 2'(y);
                rd_active = 1'b1;
                step();
                row_v = (y < 2) ? r01 : r23;
                chk("lit_pix", int'(pix_out), int'(row_v[x]));
                chk("lit_vld", int'(pix_valid), 1);
            end
        end
        rd_active = 1'b0;

        for (int i = 0; i < 3; i++) begin
            pulse_fs();
            step();
        end
        chk("underrun_3", int'(underrun_cnt), 3 * UEN);
        scan(1'b1, fa, 1'b1);
        scan(1'b0, fa, 1'b1);

        write_beats(fb, 5);
        rd_x      = 3'd3;
        rd_y      = 2'd1;
        rd_active = 1'b1;
        step();
        chk("pre_rst_vld", int'(pix_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", int'(pix_valid), 0);
        chk("async_rst_ready", int'(wr_ready), 1);
        chk("async_rst_pix", int'(pix_out), 0);
        rd_active = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        write_beats(fb, 8);
        pulse_fs();
        scan(1'b1, fb, 1'b1);

        do_reset();
        write_beats(f1, 8);
        write_beats(f2, 8);
        write_beats(f3, 8);
        chk("ring_ready", int'(wr_ready), 0);
        chk("ring_bank_full", int'(bank_full), 1);
        chk("ring_full_banks", int'(full_banks), 3);
        write_beats(f4, 1);
        chk("ring_ignored", int'(full_banks), 3);
        pulse_fs();
        chk("swap1_ready", int'(wr_ready), 0);
        chk("swap1_full", int'(full_banks), 2);
        scan(1'b1, f1, 1'b1);
        pulse_fs();
        chk("swap2_ready", int'(wr_ready), 1);
        chk("swap2_full", int'(full_banks), 1);
        scan(1'b1, f2, 1'b1);

        pulse_fs();
        chk("swap3_full", int'(full_banks), 0);
        write_beats(f4, 7);
        wr_en       = 1'b1;
        wr_data     = f4[7];
        frame_start = 1'b1;
        step();
        wr_en       = 1'b0;
        frame_start = 1'b0;
        chk("same_cycle_under", int'(underrun_cnt), UEN);
        chk("same_cycle_full", int'(full_banks), 1);
        scan(1'b1, f3, 1'b1);
        pulse_fs();
        chk("late_swap_full", int'(full_banks), 0);
        scan(1'b1, f4, 1'b1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
